debounce_multi: RTL and testbench

Multi-channel button debouncer. It is the parametrised successor of the single-channel debouncer. Per channel it provides:
- input synchronisation;
- counter-based debounce with press/release strobes;
- long-press detection;
- optional auto-repeat strobes while a button stays held.

It sits between raw board buttons/switches and UI/control logic (e.g. pan/zoom controls), all in the system clock domain.

---
 rtl/debounce_multi.sv | 145 ++++++++++++++
 tb/tb_debounce_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// Multi-channel button debouncer.
// Each channel synchronises its raw input, debounces it with a counter,
// tracks a press FSM for long-press detection and optionally emits
// auto-repeat strobes while the button stays held.
module debounce_multi #(
    parameter int CH          = 4,
    parameter int CNT_W       = 18,
    parameter int HOLD_W      = 26,
    parameter int REP_W       = 23,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CH-1:0] in,
    input  logic          repeat_en,
    output logic [CH-1:0] out,
    output logic [CH-1:0] ondn,
    output logic [CH-1:0] onup,
    output logic [CH-1:0] onhold,
    output logic [CH-1:0] onrep
);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        HELD     = 2'd2
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_reg;
            logic [CNT_W-1:0]       cnt_reg;
            logic [CNT_W-1:0]       cnt_next;
            logic                   out_reg;
            logic                   out_next;
            state_t                 state_reg;
            state_t                 state_next;
            logic [HOLD_W-1:0]      hold_reg;
            logic [HOLD_W-1:0]      hold_next;
            logic [REP_W-1:0]       rep_reg;
            logic [REP_W-1:0]       rep_next;
            logic                   s;
            logic                   idle;
            logic                   cnt_max;
            logic                   dn_strobe;
            logic                   up_strobe;
            logic                   hold_strobe;
            logic                   rep_strobe;

            // Shift the raw input through the synchroniser chain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg <= '0;
                end else begin
                    sync_reg <= {sync_reg[SYNC_STAGES-2:0], in[gi]};
                end
            end

            assign s         = sync_reg[SYNC_STAGES-1];
            assign idle      = (out_reg == s);
            assign cnt_max   = &cnt_reg;
            // Strobes fire in the cycle before the debounced level flips.
            assign dn_strobe = ~idle & cnt_max & ~out_reg;
            assign up_strobe = ~idle & cnt_max & out_reg;

            // Debounce counter: any return to the current level restarts the count.
            always_comb begin
                cnt_next = idle ? '0 : cnt_reg + CNT_W'(1);
                out_next = out_reg ^ (~idle & cnt_max);
            end

            // Debounce counter and debounced level registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                    out_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    out_reg <= out_next;
                end
            end

            // Press FSM next-state and strobe decode; a release overrides everything.
            always_comb begin
                state_next  = state_reg;
                hold_next   = hold_reg;
                rep_next    = rep_reg;
                hold_strobe = 1'b0;
                rep_strobe  = 1'b0;
                case (state_reg)
                    RELEASED: begin
                        hold_next = '0;
                        rep_next  = '0;
                        if (dn_strobe) begin
                            state_next = PRESSED;
                        end
                    end
                    PRESSED: begin
                        hold_next = hold_reg + HOLD_W'(1);
                        if (&hold_reg) begin
                            hold_strobe = ~up_strobe;
                            state_next  = HELD;
                            rep_next    = '0;
                        end
                    end
                    HELD: begin
                        // The counter runs regardless of repeat_en so the repeat
                        // phase is preserved when repeat is re-enabled.
                        rep_next   = rep_reg + REP_W'(1);
                        rep_strobe = (&rep_reg) & repeat_en & ~up_strobe;
                    end
                    default: begin
                        state_next = RELEASED;
                    end
                endcase
                if (up_strobe) begin
                    state_next = RELEASED;
                    hold_next  = '0;
                    rep_next   = '0;
                end
            end

            // Press FSM state and hold/repeat counter registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= RELEASED;
                    hold_reg  <= '0;
                    rep_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    hold_reg  <= hold_next;
                    rep_reg   <= rep_next;
                end
            end

            assign out[gi]    = out_reg;
            assign ondn[gi]   = dn_strobe;
            assign onup[gi]   = up_strobe;
            assign onhold[gi] = hold_strobe;
            assign onrep[gi]  = rep_strobe;
        end
    endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// Testbench for debounce_multi: directed press/hold/release/reset scenarios
// followed by randomized bouncing inputs, all checked every cycle against
// a behavioural model based on mismatch streaks and press age.
module tb_debounce_multi;

    localparam int CH          = 2;
    localparam int CNT_W       = 3;
    localparam int HOLD_W      = 4;
    localparam int REP_W       = 3;
    localparam int SYNC_STAGES = 2;
    localparam int N = 1 << CNT_W;
    localparam int H = 1 << HOLD_W;
    localparam int R = 1 << REP_W;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          repeat_en = 1'b0;
    logic [CH-1:0] in_v      = '0;
    logic [CH-1:0] out;
    logic [CH-1:0] ondn;
    logic [CH-1:0] onup;
    logic [CH-1:0] onhold;
    logic [CH-1:0] onrep;

    int checks   = 0;
    int failures = 0;

    // Model state: synchroniser history, length of the current run of cycles
    // where the synchronised input disagrees with the debounced level, the
    // debounced level, and the number of cycles since the level rose (-1 = released).
    int m_sync[CH][SYNC_STAGES];
    int m_streak[CH];
    int m_out[CH];
    int m_age[CH];
    int rem[CH];

    always #5 clk = ~clk;

    debounce_multi #(
        .CH(CH), .CNT_W(CNT_W), .HOLD_W(HOLD_W), .REP_W(REP_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_v), .repeat_en(repeat_en),
        .out(out), .ondn(ondn), .onup(onup), .onhold(onhold), .onrep(onrep)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < SYNC_STAGES; k++) m_sync[c][k] = 0;
            m_streak[c] = 0;
            m_out[c]    = 0;
            m_age[c]    = -1;
        end
    endfunction

    // Advance the model across one rising edge using the pre-edge inputs.
    function automatic void model_edge();
        for (int c = 0; c < CH; c++) begin
            int  s;
            bit  flipped;
            s       = m_sync[c][SYNC_STAGES-1];
            flipped = 1'b0;
            if (s != m_out[c]) begin
                if (m_streak[c] == N - 1) begin
                    m_out[c]    = s;
                    m_streak[c] = 0;
                    m_age[c]    = (s != 0) ? 0 : -1;
                    flipped     = 1'b1;
                end else begin
                    m_streak[c]++;
                end
            end else begin
                m_streak[c] = 0;
            end
            if (!flipped && m_out[c] != 0) m_age[c]++;
            for (int k = SYNC_STAGES - 1; k > 0; k--) m_sync[c][k] = m_sync[c][k-1];
            m_sync[c][0] = in_v[c] ? 1 : 0;
        end
    endfunction

    task automatic compare_outputs();
        logic [CH-1:0] e_out, e_dn, e_up, e_hold, e_rep;
        for (int c = 0; c < CH; c++) begin
            bit fl;
            fl        = (m_sync[c][SYNC_STAGES-1] != m_out[c]) && (m_streak[c] == N - 1);
            e_out[c]  = (m_out[c] != 0);
            e_dn[c]   = fl && (m_out[c] == 0);
            e_up[c]   = fl && (m_out[c] != 0);
            e_hold[c] = (m_out[c] != 0) && (m_age[c] == H - 1) && !e_up[c];
            e_rep[c]  = (m_out[c] != 0) && (m_age[c] >= H) && (((m_age[c] - H) % R) == R - 1)
                        && repeat_en && !e_up[c];
        end
        check("out", 32'(out), 32'(e_out));
        check("ondn", 32'(ondn), 32'(e_dn));
        check("onup", 32'(onup), 32'(e_up));
        check("onhold", 32'(onhold), 32'(e_hold));
        check("onrep", 32'(onrep), 32'(e_rep));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else        model_edge();
        compare_outputs();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_outputs();
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=running exp=finished", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        #1;
        compare_outputs();
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;

        // Clean press on channel 0, then long hold with repeat enabled.
        in_v = 2'b01;
        repeat (12) step();
        repeat_en = 1'b1;
        repeat (40) step();
        in_v = 2'b00;
        repeat (14) step();

        // Hold with repeat disabled, then enable it while held.
        repeat_en = 1'b0;
        in_v      = 2'b01;
        repeat (34) step();
        repeat_en = 1'b1;
        repeat (20) step();
        in_v = 2'b00;
        repeat (14) step();

        // Release timed so the release strobe lands on the long-press cycle.
        in_v = 2'b01;
        for (int k = 0; k < 40 && m_age[0] != H - 1 - (SYNC_STAGES + N - 1); k++) step();
        in_v = 2'b00;
        repeat (14) step();
        in_v = 2'b01;
        repeat (32) step();
        in_v = 2'b00;
        repeat (14) step();

        // Both channels pressed together, reset mid-hold, then re-debounce.
        in_v = 2'b11;
        repeat (14) step();
        pulse_reset();
        repeat (30) step();
        in_v = 2'b00;
        repeat (14) step();

        // Randomized bouncing and holds on every channel.
        for (int c = 0; c < CH; c++) rem[c] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < CH; c++) begin
                if (rem[c] == 0) begin
                    in_v[c] = ~in_v[c];
                    rem[c]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7))
                                                         : int'($urandom_range(8, 80));
                end
                rem[c]--;
            end
            if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
            if ($urandom_range(0, 999) == 0) pulse_reset();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
